// File: rtl/or_gate_unit.sv
// ---------------------------------------------------------------------------
// or_gate_unit
//   Bitwise two-input OR gate with a registered monitor path.
//   `out` is purely combinational and never depends on clk or rst, so the
//   gate remains usable in a domain whose clock is stopped or held in reset.
//   The registered side-band outputs are for downstream synchronous logic.
//
// Parameters
//   WIDTH     bit width of the operands and the per-bit outputs
//   CNT_W     width of the saturating hi_count counter
//
// Ports
//   clk       single clock, all registers update on its rising edge
//   rst       asynchronous, active-high reset of the registered outputs
//   in_a      operand A
//   in_b      operand B
//   out       combinational in_a | in_b
//   out_q     out registered once
//   out_rise  per-bit one-cycle pulse, high in the cycle out_q first shows 1
//   hi_count  saturating count of edges on which any bit of out was 1
// ---------------------------------------------------------------------------
module or_gate_unit #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_rise,
    output logic [CNT_W-1:0] hi_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] w_or;
    logic             w_any_hi;
    logic             w_cnt_inc;

    logic [WIDTH-1:0] r_out_q;
    logic [WIDTH-1:0] r_out_rise;
    logic [CNT_W-1:0] r_hi_count;

    // The gate itself: no clock or reset anywhere on this path.
    assign w_or      = in_a | in_b;
    assign w_any_hi  = |w_or;
    // Stop at all-ones instead of wrapping.
    assign w_cnt_inc = w_any_hi && (r_hi_count != CNT_MAX);

    // Sampled copy of the gate and its rising-edge detector. The previous
    // out_q is the history, so after reset a high out pulses out_rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q    <= '0;
            r_out_rise <= '0;
        end else begin
            r_out_q    <= w_or;
            r_out_rise <= w_or & ~r_out_q;
        end
    end

    // Saturating count of edges on which any output bit was high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi_count <= '0;
        end else if (w_cnt_inc) begin
            r_hi_count <= r_hi_count + CNT_ONE;
        end
    end

    assign out      = w_or;
    assign out_q    = r_out_q;
    assign out_rise = r_out_rise;
    assign hi_count = r_hi_count;

endmodule

// File: tb/tb_or_gate_unit.sv
module tb_or_gate_unit;

    localparam int unsigned W4   = 4;
    localparam int unsigned C16  = 16;
    localparam int unsigned W1   = 1;
    localparam int unsigned C2   = 2;

    localparam int F_OUT  = 0;
    localparam int F_Q    = 1;
    localparam int F_RISE = 2;
    localparam int F_CNT  = 3;

    typedef struct {
        int          unit;
        int          fld;
        logic [15:0] exp;
        string       name;
    } sb_item_t;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst    = 1'b1;

    logic [W4-1:0]  a4 = '0;
    logic [W4-1:0]  b4 = '0;
    logic [W4-1:0]  out4, q4, rise4;
    logic [C16-1:0] cnt4;

    logic [W1-1:0]  a1 = '0;
    logic [W1-1:0]  b1 = '0;
    logic [W1-1:0]  out1, q1, rise1;
    logic [C2-1:0]  cnt1;

    sb_item_t sb_q[$];
    event     sb_ev;
    int       n_checks = 0;
    int       n_errors = 0;

    or_gate_unit #(.WIDTH(W4), .CNT_W(C16)) u_w4 (
        .clk(clk), .rst(rst), .in_a(a4), .in_b(b4),
        .out(out4), .out_q(q4), .out_rise(rise4), .hi_count(cnt4)
    );

    or_gate_unit #(.WIDTH(W1), .CNT_W(C2)) u_w1 (
        .clk(clk), .rst(rst), .in_a(a1), .in_b(b1),
        .out(out1), .out_q(q1), .out_rise(rise1), .hi_count(cnt1)
    );

    // Gated clock: static low until clk_en is raised.
    initial forever #5 if (clk_en) clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] get_act(input int unit, input int fld);
        logic [15:0] v;
        v = 'x;
        if (unit == 4) begin
            case (fld)
                F_OUT:   v = 16'(out4);
                F_Q:     v = 16'(q4);
                F_RISE:  v = 16'(rise4);
                default: v = 16'(cnt4);
            endcase
        end else begin
            case (fld)
                F_OUT:   v = 16'(out1);
                F_Q:     v = 16'(q1);
                F_RISE:  v = 16'(rise1);
                default: v = 16'(cnt1);
            endcase
        end
        return v;
    endfunction

    // Monitor: compare every queued expectation against the live outputs.
    initial forever begin
        @(sb_ev);
        while (sb_q.size() != 0) begin
            sb_item_t    it;
            logic [15:0] act;
            it  = sb_q.pop_front();
            act = get_act(it.unit, it.fld);
            n_checks++;
            if (act !== it.exp) begin
                n_errors++;
                $display("FAIL %s (u%0d f%0d): got %0h expected %0h",
                         it.name, it.unit, it.fld, act, it.exp);
            end
        end
    end

    task automatic push(input int unit, input int fld, input logic [15:0] e,
                        input string n);
        sb_item_t it;
        it.unit = unit; it.fld = fld; it.exp = e; it.name = n;
        sb_q.push_back(it);
    endtask

    task automatic push_regs(input int unit, input logic [15:0] q,
                             input logic [15:0] r, input logic [15:0] c,
                             input string n);
        push(unit, F_Q,    q, {n, ".out_q"});
        push(unit, F_RISE, r, {n, ".out_rise"});
        push(unit, F_CNT,  c, {n, ".hi_count"});
    endtask

    // Hand the queued items to the monitor and hold inputs for 1 time unit.
    task automatic flush();
        -> sb_ev;
        #1;
    endtask

    logic        tt_a [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        tt_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        tt_e [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  va   [4] = '{4'b1010, 4'b0000, 4'b1111, 4'b0011};
    logic [3:0]  vb   [4] = '{4'b0110, 4'b0000, 4'b0000, 4'b1100};
    logic [3:0]  ve   [4] = '{4'b1110, 4'b0000, 4'b1111, 4'b1111};

    // Per-edge expectations: u_w4 high for edges 1..5, u_w1 for edges 1..6.
    logic [15:0] dq [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [15:0] dr [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] dc [9] = '{1, 2, 3, 4, 5, 5, 5, 5, 5};
    logic [15:0] sq [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [15:0] sr [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] sc [9] = '{1, 2, 3, 3, 3, 3, 3, 3, 3};

    initial begin
        // Reset applied with no clock at all.
        #1;
        push(4, F_OUT, 16'h0, "rst.out");
        push_regs(4, 16'h0, 16'h0, 16'h0, "rst");
        push(1, F_OUT, 16'h0, "rst.out");
        push_regs(1, 16'h0, 16'h0, 16'h0, "rst");
        flush();

        // Clock stopped, reset held: gate still follows the inputs.
        a1 = 1'b1; a4 = 4'b0101;
        #1;
        push(1, F_OUT, 16'h1, "rsthold.out");
        push(4, F_OUT, 16'h5, "rsthold.out");
        push_regs(4, 16'h0, 16'h0, 16'h0, "rsthold");
        push_regs(1, 16'h0, 16'h0, 16'h0, "rsthold");
        flush();

        // Reset released, clock still static: truth table and vectors.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a1 = tt_a[i]; b1 = tt_b[i];
            a4 = va[i];   b4 = vb[i];
            #1;
            push(1, F_OUT, 16'(tt_e[i]), $sformatf("tt%0d.out", i));
            push(4, F_OUT, 16'(ve[i]),   $sformatf("vec%0d.out", i));
            flush();
            #8;
        end
        push_regs(4, 16'h0, 16'h0, 16'h0, "noclk");
        push_regs(1, 16'h0, 16'h0, 16'h0, "noclk");
        flush();

        // Start the clock with both gates low.
        a1 = '0; b1 = '0; a4 = '0; b4 = '0;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_regs(4, 16'h0, 16'h0, 16'h0, "idle");
        push_regs(1, 16'h0, 16'h0, 16'h0, "idle");
        flush();

        // Registered path, rise pulse and counter / saturation.
        for (int k = 0; k < 9; k++) begin
            a4 = (k < 5) ? 4'b0001 : 4'b0000;
            a1 = (k < 6) ? 1'b1 : 1'b0;
            @(posedge clk);
            @(negedge clk);
            push_regs(4, dq[k], dr[k], dc[k], $sformatf("edge%0d", k + 1));
            push_regs(1, sq[k], sr[k], sc[k], $sformatf("edge%0d", k + 1));
            flush();
        end

        // Bring u_w4 to out_q=0111 and hi_count=7.
        a4 = 4'b0011; b4 = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        push_regs(4, 16'h7, 16'h7, 16'd6, "pre1");
        flush();
        @(posedge clk);
        @(negedge clk);
        push_regs(4, 16'h7, 16'h0, 16'd7, "pre2");
        push_regs(1, 16'h0, 16'h0, 16'd3, "pre2");
        flush();

        // Asynchronous reset between edges.
        #1;
        rst = 1'b1;
        a1  = 1'b1;
        #1;
        push(4, F_OUT, 16'h7, "arst.out");
        push_regs(4, 16'h0, 16'h0, 16'h0, "arst");
        push(1, F_OUT, 16'h1, "arst.out");
        push_regs(1, 16'h0, 16'h0, 16'h0, "arst");
        flush();
        rst = 1'b0;

        // First edge after release with out already high.
        @(posedge clk);
        @(negedge clk);
        push_regs(4, 16'h7, 16'h7, 16'd1, "post1");
        push_regs(1, 16'h1, 16'h1, 16'd1, "post1");
        flush();
        @(posedge clk);
        @(negedge clk);
        push_regs(4, 16'h7, 16'h0, 16'd2, "post2");
        push_regs(1, 16'h1, 16'h0, 16'd2, "post2");
        flush();

        // Direct spot checks of the final state.
        n_checks++;
        if (out4 !== 4'h7) begin
            n_errors++;
            $display("FAIL final.out4: got %0h expected %0h", out4, 4'h7);
        end
        n_checks++;
        if (q4 !== 4'h7) begin
            n_errors++;
            $display("FAIL final.q4: got %0h expected %0h", q4, 4'h7);
        end
        n_checks++;
        if (rise4 !== 4'h0) begin
            n_errors++;
            $display("FAIL final.rise4: got %0h expected %0h", rise4, 4'h0);
        end
        n_checks++;
        if (cnt4 !== 16'd2) begin
            n_errors++;
            $display("FAIL final.cnt4: got %0h expected %0h", cnt4, 16'd2);
        end
        n_checks++;
        if (q1 !== 1'b1) begin
            n_errors++;
            $display("FAIL final.q1: got %0h expected %0h", q1, 1'b1);
        end
        n_checks++;
        if (cnt1 !== 2'd2) begin
            n_errors++;
            $display("FAIL final.cnt1: got %0h expected %0h", cnt1, 2'd2);
        end

        #5;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
